// File: rtl/apb_to_ahb_bridge.sv
// AHB-Lite slave to APB master bridge: one AHB transfer becomes one APB SETUP+ACCESS pair.
// Optional macro APB_BRIDGE_RDATA_REG_EN adds a DONE state that registers PRDATA before it reaches HRDATA.
module apb_to_ahb_bridge #(
    parameter  int DATA_W  = 32,
    parameter  int PADDR_W = 5,
    parameter  int NSLV    = 4,
    localparam int SLV_W   = (NSLV > 1) ? $clog2(NSLV) : 1,
    localparam int HADDR_W = SLV_W + PADDR_W
) (
    input  logic               HCLK,
    input  logic               RESET_n,
    input  logic               HSEL,
    input  logic [HADDR_W-1:0] HADDR,
    input  logic               HWRITE,
    input  logic               HREADY,
    input  logic [DATA_W-1:0]  HWDATA,
    output logic               HREADYOUT,
    output logic [DATA_W-1:0]  HRDATA,
    output logic [NSLV-1:0]    PSEL,
    output logic [PADDR_W-1:0] PADDR,
    output logic               PENABLE,
    output logic               PWRITE,
    output logic [DATA_W-1:0]  PWDATA,
    input  logic [DATA_W-1:0]  PRDATA,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [SLV_W-1:0]     slv_q, slv_d;
    logic [PADDR_W-1:0]   paddr_q, paddr_d;
    logic                 pwrite_q, pwrite_d;
    logic [DATA_W-1:0]    pwdata_q, pwdata_d;
`ifdef APB_BRIDGE_RDATA_REG_EN
    logic [DATA_W-1:0]    hrdata_q, hrdata_d;
`endif
    logic                 accept;

    // Valid/ready: a transfer is taken on the edge where HSEL, HREADY and HREADYOUT are all high;
    // the master must hold its request while HREADYOUT is low.
    assign accept    = HSEL & HREADY & HREADYOUT;
    assign dbg_state = state_q;

    // State register
    always_ff @(posedge HCLK) begin
        if (!RESET_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = accept ? ST_SETUP : ST_IDLE;
            ST_SETUP:  state_d = ST_ACCESS;
`ifdef APB_BRIDGE_RDATA_REG_EN
            ST_ACCESS: state_d = ST_DONE;
`else
            ST_ACCESS: state_d = accept ? ST_SETUP : ST_IDLE;
`endif
            ST_DONE:   state_d = accept ? ST_SETUP : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output logic; APB address/control are forced to zero outside SETUP/ACCESS
    always_comb begin
        HREADYOUT = 1'b1;
        PSEL      = '0;
        PADDR     = '0;
        PENABLE   = 1'b0;
        PWRITE    = 1'b0;
        PWDATA    = pwdata_q;
        HRDATA    = '0;
        case (state_q)
            ST_SETUP: begin
                HREADYOUT   = 1'b0;
                PSEL[slv_q] = 1'b1;
                PADDR       = paddr_q;
                PWRITE      = pwrite_q;
                PWDATA      = HWDATA;
            end
            ST_ACCESS: begin
                PSEL[slv_q] = 1'b1;
                PADDR       = paddr_q;
                PENABLE     = 1'b1;
                PWRITE      = pwrite_q;
`ifdef APB_BRIDGE_RDATA_REG_EN
                HREADYOUT   = 1'b0;
`else
                if (!pwrite_q) begin
                    HRDATA = PRDATA;
                end
`endif
            end
            default: begin
            end
        endcase
`ifdef APB_BRIDGE_RDATA_REG_EN
        HRDATA = hrdata_q;
`endif
    end

    // Datapath next values: address captured on acceptance, write data at SETUP->ACCESS
    always_comb begin
        slv_d    = slv_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        if (accept) begin
            slv_d    = HADDR[HADDR_W-1:PADDR_W];
            paddr_d  = HADDR[PADDR_W-1:0];
            pwrite_d = HWRITE;
        end
        if (state_q == ST_SETUP) begin
            pwdata_d = HWDATA;
        end
    end

`ifdef APB_BRIDGE_RDATA_REG_EN
    // Read data is latched only when a read leaves ACCESS, so it holds across writes
    always_comb begin
        hrdata_d = hrdata_q;
        if (state_q == ST_ACCESS && !pwrite_q) begin
            hrdata_d = PRDATA;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!RESET_n) begin
            hrdata_q <= '0;
        end else begin
            hrdata_q <= hrdata_d;
        end
    end
`endif

    always_ff @(posedge HCLK) begin
        if (!RESET_n) begin
            slv_q    <= '0;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
        end else begin
            slv_q    <= slv_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
        end
    end

endmodule

// File: tb/tb_apb_to_ahb_bridge.sv
// Directed, table-driven bench for apb_to_ahb_bridge: one record per clock cycle of inputs and expected outputs.
// Build with APB_BRIDGE_RDATA_REG_EN defined to exercise the registered read-data table instead.
module tb_apb_to_ahb_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hsel, hwrite, hready;
    logic [6:0]  haddr;
    logic [31:0] hwdata, prdata;
    logic        hreadyout, penable, pwrite;
    logic [31:0] hrdata, pwdata;
    logic [3:0]  psel;
    logic [4:0]  paddr;
    logic [1:0]  dbg_state;

    int passed = 0;
    int total  = 0;

    localparam logic [1:0] S_I = 2'd0, S_S = 2'd1, S_A = 2'd2, S_D = 2'd3;

    typedef struct {
        logic        rst_n, hsel, hwrite, hready;
        logic [6:0]  haddr;
        logic [31:0] hwdata, prdata;
        logic [3:0]  e_psel;
        logic [4:0]  e_paddr;
        logic        e_pen, e_pwrite, e_hro;
        logic [31:0] e_pwdata, e_hrdata;
        logic [1:0]  e_state;
    } vec_t;

    vec_t vecs[$];

    apb_to_ahb_bridge dut (
        .HCLK(clk), .RESET_n(rst_n), .HSEL(hsel), .HADDR(haddr), .HWRITE(hwrite),
        .HREADY(hready), .HWDATA(hwdata), .HREADYOUT(hreadyout), .HRDATA(hrdata),
        .PSEL(psel), .PADDR(paddr), .PENABLE(penable), .PWRITE(pwrite),
        .PWDATA(pwdata), .PRDATA(prdata), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic s, input logic [6:0] a, input logic w,
                       input logic rdy, input logic [31:0] wd, input logic [31:0] rd,
                       input logic [3:0] e_ps, input logic [4:0] e_pa, input logic e_pe,
                       input logic e_pw, input logic [31:0] e_wd, input logic e_ro,
                       input logic [31:0] e_rd, input logic [1:0] e_st);
        vec_t v;
        v.rst_n = r;      v.hsel = s;        v.haddr = a;      v.hwrite = w;
        v.hready = rdy;   v.hwdata = wd;     v.prdata = rd;
        v.e_psel = e_ps;  v.e_paddr = e_pa;  v.e_pen = e_pe;   v.e_pwrite = e_pw;
        v.e_pwdata = e_wd; v.e_hro = e_ro;   v.e_hrdata = e_rd; v.e_state = e_st;
        vecs.push_back(v);
    endtask

    initial begin
        rst_n = 1'b0; hsel = 1'b0; haddr = '0; hwrite = 1'b0; hready = 1'b1;
        hwdata = '0; prdata = '0;

        // Reset held for 5 edges with random inputs
        for (int i = 0; i < 5; i++) begin
            rst_n  = 1'b0;
            hsel   = 1'($urandom_range(0, 1));
            hwrite = 1'($urandom_range(0, 1));
            hready = 1'($urandom_range(0, 1));
            haddr  = 7'($urandom_range(0, 127));
            hwdata = $urandom;
            prdata = $urandom;
            @(posedge clk); #1;
            @(negedge clk);
            chk("reset_psel",    i, 32'(psel),      32'h0);
            chk("reset_penable", i, 32'(penable),   32'h0);
            chk("reset_hready",  i, 32'(hreadyout), 32'h1);
            chk("reset_hrdata",  i, hrdata,         32'h0);
            chk("reset_paddr",   i, 32'(paddr),     32'h0);
            chk("reset_pwrite",  i, 32'(pwrite),    32'h0);
        end
        @(posedge clk); #1;

`ifdef APB_BRIDGE_RDATA_REG_EN
        //   rst hsel haddr         hw rdy hwdata        prdata          psel    paddr pen pw pwdata        hro hrdata        st
        add(1, 1, 7'b10_00101, 0, 1, 32'h0,         32'h0,          4'b0000, 5'd0,  0, 0, 32'h0,         1, 32'h0,         S_I);
        add(1, 0, 7'b0,        0, 1, 32'h0,         32'hA5A5_0005,  4'b0100, 5'd5,  0, 0, 32'h0,         0, 32'h0,         S_S);
        add(1, 0, 7'b0,        0, 1, 32'h0,         32'hA5A5_0005,  4'b0100, 5'd5,  1, 0, 32'h0,         0, 32'h0,         S_A);
        add(1, 0, 7'b0,        0, 1, 32'h0,         32'h0,          4'b0000, 5'd0,  0, 0, 32'h0,         1, 32'hA5A5_0005, S_D);
        add(1, 1, 7'b01_11111, 1, 1, 32'h0,         32'h0,          4'b0000, 5'd0,  0, 0, 32'h0,         1, 32'hA5A5_0005, S_I);
        add(1, 0, 7'b0,        0, 1, 32'hDEAD_BEEF, 32'h0,          4'b0010, 5'd31, 0, 1, 32'hDEAD_BEEF, 0, 32'hA5A5_0005, S_S);
        add(1, 0, 7'b0,        0, 1, 32'h0,         32'h1234_5678,  4'b0010, 5'd31, 1, 1, 32'hDEAD_BEEF, 0, 32'hA5A5_0005, S_A);
        add(1, 1, 7'b00_00011, 0, 1, 32'h0,         32'h0,          4'b0000, 5'd0,  0, 0, 32'hDEAD_BEEF, 1, 32'hA5A5_0005, S_D);
        add(1, 0, 7'b0,        0, 1, 32'h0,         32'h0,          4'b0001, 5'd3,  0, 0, 32'h0,         0, 32'hA5A5_0005, S_S);
        add(1, 0, 7'b0,        0, 1, 32'h0,         32'h0000_0007,  4'b0001, 5'd3,  1, 0, 32'h0,         0, 32'hA5A5_0005, S_A);
        add(1, 0, 7'b0,        0, 1, 32'h0,         32'h0,          4'b0000, 5'd0,  0, 0, 32'h0,         1, 32'h0000_0007, S_D);
        add(1, 0, 7'b0,        0, 1, 32'h0,         32'h0,          4'b0000, 5'd0,  0, 0, 32'h0,         1, 32'h0000_0007, S_I);
        add(1, 1, 7'b10_00101, 0, 1, 32'h0,         32'h0,          4'b0000, 5'd0,  0, 0, 32'h0,         1, 32'h0000_0007, S_I);
        add(0, 0, 7'b0,        0, 1, 32'h0,         32'h0,          4'b0100, 5'd5,  0, 0, 32'h0,         0, 32'h0000_0007, S_S);
        add(1, 0, 7'b0,        0, 1, 32'h0,         32'h0,          4'b0000, 5'd0,  0, 0, 32'h0,         1, 32'h0,         S_I);
        add(1, 0, 7'b0,        0, 1, 32'h0,         32'h0,          4'b0000, 5'd0,  0, 0, 32'h0,         1, 32'h0,         S_I);
`else
        //   rst hsel haddr         hw rdy hwdata        prdata          psel    paddr pen pw pwdata        hro hrdata        st
        add(1, 0, 7'b0,        0, 1, 32'h0,         32'h0,          4'b0000, 5'd0,  0, 0, 32'h0,         1, 32'h0,         S_I);
        add(1, 1, 7'b10_00101, 0, 1, 32'h0,         32'h0,          4'b0000, 5'd0,  0, 0, 32'h0,         1, 32'h0,         S_I);
        add(1, 0, 7'b0,        0, 1, 32'h1111_2222, 32'hA5A5_0005,  4'b0100, 5'd5,  0, 0, 32'h1111_2222, 0, 32'h0,         S_S);
        add(1, 0, 7'b0,        0, 1, 32'h0,         32'hA5A5_0005,  4'b0100, 5'd5,  1, 0, 32'h1111_2222, 1, 32'hA5A5_0005, S_A);
        add(1, 1, 7'b01_11111, 1, 1, 32'h0,         32'hA5A5_0005,  4'b0000, 5'd0,  0, 0, 32'h1111_2222, 1, 32'h0,         S_I);
        add(1, 1, 7'b11_00001, 0, 1, 32'hDEAD_BEEF, 32'h0,          4'b0010, 5'd31, 0, 1, 32'hDEAD_BEEF, 0, 32'h0,         S_S);
        add(1, 0, 7'b0,        0, 0, 32'h0,         32'h1234_5678,  4'b0010, 5'd31, 1, 1, 32'hDEAD_BEEF, 1, 32'h0,         S_A);
        add(1, 1, 7'b11_00010, 0, 0, 32'h0,         32'h0,          4'b0000, 5'd0,  0, 0, 32'hDEAD_BEEF, 1, 32'h0,         S_I);
        add(1, 1, 7'b00_00011, 0, 1, 32'h0,         32'h0,          4'b0000, 5'd0,  0, 0, 32'hDEAD_BEEF, 1, 32'h0,         S_I);
        add(1, 0, 7'b0,        0, 1, 32'h0,         32'h0,          4'b0001, 5'd3,  0, 0, 32'h0,         0, 32'h0,         S_S);
        add(1, 1, 7'b11_01001, 0, 1, 32'h0,         32'h0000_0003,  4'b0001, 5'd3,  1, 0, 32'h0,         1, 32'h0000_0003, S_A);
        add(1, 0, 7'b0,        0, 1, 32'h0,         32'h0000_0003,  4'b1000, 5'd9,  0, 0, 32'h0,         0, 32'h0,         S_S);
        add(1, 0, 7'b0,        0, 1, 32'h0,         32'h0000_0009,  4'b1000, 5'd9,  1, 0, 32'h0,         1, 32'h0000_0009, S_A);
        add(1, 0, 7'b0,        0, 1, 32'h0,         32'h0,          4'b0000, 5'd0,  0, 0, 32'h0,         1, 32'h0,         S_I);
        add(1, 1, 7'b10_00101, 0, 1, 32'h0,         32'h0,          4'b0000, 5'd0,  0, 0, 32'h0,         1, 32'h0,         S_I);
        add(0, 0, 7'b0,        0, 1, 32'h0,         32'h0,          4'b0100, 5'd5,  0, 0, 32'h0,         0, 32'h0,         S_S);
        add(1, 0, 7'b0,        0, 1, 32'h0,         32'h0,          4'b0000, 5'd0,  0, 0, 32'h0,         1, 32'h0,         S_I);
        add(1, 0, 7'b0,        0, 1, 32'h0,         32'h0,          4'b0000, 5'd0,  0, 0, 32'h0,         1, 32'h0,         S_I);
`endif

        // Each record is one cycle: drive after the edge, compare at the falling edge
        foreach (vecs[i]) begin
            rst_n  = vecs[i].rst_n;
            hsel   = vecs[i].hsel;
            haddr  = vecs[i].haddr;
            hwrite = vecs[i].hwrite;
            hready = vecs[i].hready;
            hwdata = vecs[i].hwdata;
            prdata = vecs[i].prdata;
            @(negedge clk);
            chk("psel",      i, 32'(psel),      32'(vecs[i].e_psel));
            chk("paddr",     i, 32'(paddr),     32'(vecs[i].e_paddr));
            chk("penable",   i, 32'(penable),   32'(vecs[i].e_pen));
            chk("pwrite",    i, 32'(pwrite),    32'(vecs[i].e_pwrite));
            chk("pwdata",    i, pwdata,         vecs[i].e_pwdata);
            chk("hreadyout", i, 32'(hreadyout), 32'(vecs[i].e_hro));
            chk("hrdata",    i, hrdata,         vecs[i].e_hrdata);
            chk("state",     i, 32'(dbg_state), 32'(vecs[i].e_state));
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/apb_to_ahb_bridge.md
APB_TO_AHB_BRIDGE -- requirements
Module: apb_to_ahb_bridge

Interface
REQ-001 Parameters SHALL be: DATA_W, 32, AHB/APB data width; PADDR_W, 5, APB address width; NSLV, 4, number of APB slaves, one-hot select width.
REQ-002 HCLK  in  1  the single clock; all state updates on the rising edge.
REQ-003 RESET_n  in  1  reset, synchronous and active-low.
REQ-004 HSEL  in  1  bridge selected by the AHB decoder.
REQ-005 HADDR  in  7  [6:5] slave index, [4:0] APB register address.
REQ-006 HWRITE  in  1  1 = write, 0 = read.
REQ-007 HREADY  in  1  AHB bus ready; qualifies the address phase.
REQ-008 HWDATA  in  32  write data, valid in the cycle after the address phase.
REQ-009 HREADYOUT  out  1  bridge ready; 0 stalls the master.
REQ-010 HRDATA  out  32  read data to the AHB master.
REQ-011 PSEL  out  4  one-hot APB slave select.
REQ-012 PADDR  out  5  APB address.
REQ-013 PENABLE  out  1  APB access phase.
REQ-014 PWRITE  out  1  APB direction.
REQ-015 PWDATA  out  32  APB write data.
REQ-016 PRDATA  in  32  read data from the selected APB slave.

Function
REQ-017 A transfer SHALL be accepted on a rising edge when HSEL=1, HREADY=1 and HREADYOUT=1; HADDR and HWRITE are captured into internal registers at that edge.
REQ-018 FSM states SHALL be IDLE, SETUP and ACCESS, plus DONE when the macro in REQ-029 is defined.
- IDLE: on acceptance, go to SETUP; otherwise stay in IDLE.
- SETUP: always go to ACCESS.
- ACCESS (macro undefined): on acceptance, go to SETUP; otherwise go to IDLE.
REQ-019 PSEL SHALL be one-hot decoded from captured HADDR[6:5]: 00->0001, 01->0010, 10->0100, 11->1000. PSEL is nonzero only in SETUP and ACCESS.
REQ-020 PADDR and PWRITE SHALL equal the captured HADDR[4:0] and HWRITE throughout SETUP and ACCESS.
REQ-021 PENABLE SHALL be 0 in SETUP and 1 in ACCESS.
REQ-022 The SETUP-to-ACCESS sequence takes exactly 2 cycles; there is no PREADY, so ACCESS is always one cycle.
REQ-023 PWDATA SHALL follow HWDATA combinationally in SETUP. HWDATA is registered at the SETUP->ACCESS edge, and that register drives PWDATA in ACCESS.
REQ-024 HREADYOUT SHALL be 1 in IDLE and ACCESS, and 0 in SETUP.
- The master therefore sees one wait state per transfer.
- Back-to-back transfers proceed ACCESS->SETUP with no IDLE cycle.
REQ-025 HRDATA SHALL equal PRDATA during ACCESS of a read (macro undefined), and 0 at all other times.
REQ-026 HSEL asserted while HREADYOUT=0 SHALL be ignored; the master holds the request until HREADYOUT=1.
REQ-027 When HREADY=0, no transfer is accepted; a transfer already in progress SHALL complete normally.

Reset
REQ-028 While RESET_n=0 at a rising edge, the following SHALL be set:
- state IDLE;
- PSEL=0, PENABLE=0, PWRITE=0, PADDR=0;
- PWDATA register and HRDATA register = 0;
- HREADYOUT=1.
Reset asserted mid-transfer SHALL abort the transfer, with no further APB activity.

Configuration
REQ-029 Macro APB_BRIDGE_RDATA_REG_EN:
- When defined: ACCESS always goes to DONE, and HREADYOUT is 0 in ACCESS. PRDATA is registered at the ACCESS->DONE edge, and HRDATA drives that register in DONE and holds it until the next read completes. In DONE, HREADYOUT=1, PSEL=0 and PENABLE=0; on acceptance DONE goes to SETUP, otherwise to IDLE. Read latency grows by one cycle.
- When undefined: behaviour is exactly as in REQ-018 to REQ-025.

Verification
REQ-030 Reset: RESET_n=0 for 5 cycles with random inputs -> PSEL=0000, PENABLE=0, HREADYOUT=1, HRDATA=0.
REQ-031 Single read: HADDR=7'b10_00101, HWRITE=0, slave 2 returns 32'hA5A5_0005.
- Next cycle: PSEL=0100, PADDR=5, PENABLE=0, HREADYOUT=0.
- Following cycle: PENABLE=1, HRDATA=32'hA5A5_0005, HREADYOUT=1.
REQ-032 Single write: HADDR=7'b01_11111, HWRITE=1, HWDATA=32'hDEAD_BEEF in the data phase.
- Required: PSEL=0010, PWRITE=1, PADDR=31, PWDATA=32'hDEAD_BEEF in both SETUP and ACCESS.
REQ-033 Back-to-back: two reads (slave 0 addr 3, then slave 3 addr 9) accepted on consecutive ready cycles.
- Required: PENABLE pattern 0,1,0,1; PSEL 0001,0001,1000,1000; no IDLE cycle between them.
REQ-034 Stall/HREADY: HSEL=1 during SETUP is ignored; HSEL=1 with HREADY=0 in IDLE produces no PSEL.
REQ-035 Reset in SETUP: RESET_n=0 -> PSEL=0000 and PENABLE=0 at the next edge, with no ACCESS cycle. With APB_BRIDGE_RDATA_REG_EN defined, REQ-031 is repeated and HRDATA is valid one cycle later, in DONE.
